// File: rtl/clause_array_bcp.sv
// One bin of clauses: literal storage, valid/learnt flags, free-slot search and a
// 3-stage pipelined unit-propagation evaluation with conflict detection.
module clause_array_bcp #(
  parameter int unsigned NUM_CLAUSES_A_BIN = 2,
  parameter int unsigned NUM_VARS_A_BIN    = 8,
  parameter int unsigned WIDTH_C_LEN       = 5,
  parameter int unsigned WIDTH_C_IDX       = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_CLAUSES_A_BIN-1:0]             wr_i,
  input  logic [2*NUM_VARS_A_BIN-1:0]              lit_i,
  input  logic                                     learnt_i,
  input  logic [WIDTH_C_LEN-1:0]                   clause_len_i,
  input  logic                                     start_i,
  input  logic [3*NUM_VARS_A_BIN-1:0]              var_value_frombase_i,
  output logic [3*NUM_VARS_A_BIN-1:0]              var_value_tobase_o,
  output logic [WIDTH_C_LEN*NUM_CLAUSES_A_BIN-1:0] clause_len_o,
  input  logic                                     apply_backtrack_i,
  output logic                                     busy_o,
  output logic                                     done_o,
  output logic                                     conflict_o,
  output logic [WIDTH_C_IDX-1:0]                   conflict_idx_o,
  output logic [WIDTH_C_IDX-1:0]                   free_idx_o,
  output logic                                     full_o
);

  localparam int unsigned N = NUM_CLAUSES_A_BIN;
  localparam int unsigned V = NUM_VARS_A_BIN;

  typedef enum logic [1:0] {StIdle, StS1, StS2, StS3} state_e;

  state_e state_q, state_d;

  // Clause storage
  logic [2*V-1:0]         lit_q    [N];
  logic [WIDTH_C_LEN-1:0] len_q    [N];
  logic [N-1:0]           learnt_q;
  logic [N-1:0]           valid_q;

  // Variable snapshot taken when an evaluation is accepted
  logic [V-1:0] asg_q, val_q;

  // Stage-1 results: conflict flag and polarity-split unit implications per clause
  logic [N-1:0] conf_q;
  logic [V-1:0] pos_q [N];
  logic [V-1:0] neg_q [N];

  // Evaluation outputs
  logic [3*V-1:0]         tobase_q;
  logic                   conflict_q;
  logic [WIDTH_C_IDX-1:0] conflict_idx_q;

  // Only assigned/value are meaningful in the incoming triplets
  logic [V-1:0] spare_bits;
  logic         unused_spare;
  assign unused_spare = ^spare_bits;

  always_comb begin
    spare_bits = '0;
    for (int i = 0; i < int'(V); i++) begin
      spare_bits[i] = var_value_frombase_i[3*i];
    end
  end

  // FSM
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StS1;
      StS1:    state_d = StS2;
      StS2:    state_d = StS3;
      StS3:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (apply_backtrack_i) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Stage 1: per-clause literal classification
  logic [V-1:0] true_v [N];
  logic [V-1:0] free_v [N];
  logic [V-1:0] pol_v  [N];
  logic [N-1:0] st_conf, st_unit;

  always_comb begin
    st_conf = '0;
    st_unit = '0;
    for (int k = 0; k < int'(N); k++) begin
      true_v[k] = '0;
      free_v[k] = '0;
      pol_v[k]  = '0;
      for (int i = 0; i < int'(V); i++) begin
        pol_v[k][i]  = lit_q[k][2*i];
        true_v[k][i] = lit_q[k][2*i+1] & asg_q[i] & (val_q[i] == lit_q[k][2*i]);
        free_v[k][i] = lit_q[k][2*i+1] & ~asg_q[i];
      end
      // An empty clause has no free literal and no true literal, so it lands in conflict
      st_conf[k] = valid_q[k] & ~(|true_v[k]) & (free_v[k] == '0);
      st_unit[k] = valid_q[k] & ~(|true_v[k]) & (free_v[k] != '0) &
                   ((free_v[k] & (free_v[k] - V'(1))) == '0);
    end
  end

  // Stage 2: implication merge and conflict priority encode
  logic [V-1:0]           imp_pos, imp_neg;
  logic [3*V-1:0]         tobase_d;
  logic                   conflict_d;
  logic [WIDTH_C_IDX-1:0] conflict_idx_d;

  always_comb begin
    imp_pos        = '0;
    imp_neg        = '0;
    tobase_d       = '0;
    conflict_idx_d = '0;
    for (int k = 0; k < int'(N); k++) begin
      imp_pos = imp_pos | pos_q[k];
      imp_neg = imp_neg | neg_q[k];
    end
    for (int i = 0; i < int'(V); i++) begin
      tobase_d[3*i+2] = imp_pos[i] | imp_neg[i];
      tobase_d[3*i+1] = imp_pos[i];
      tobase_d[3*i]   = imp_pos[i] & imp_neg[i];
    end
    conflict_d = (|conf_q) | (|(imp_pos & imp_neg));
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (conf_q[k]) conflict_idx_d = WIDTH_C_IDX'(k);
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      learnt_q       <= '0;
      valid_q        <= '0;
      asg_q          <= '0;
      val_q          <= '0;
      conf_q         <= '0;
      tobase_q       <= '0;
      conflict_q     <= 1'b0;
      conflict_idx_q <= '0;
      for (int k = 0; k < int'(N); k++) begin
        lit_q[k] <= '0;
        len_q[k] <= '0;
        pos_q[k] <= '0;
        neg_q[k] <= '0;
      end
    end else if (apply_backtrack_i) begin
      conf_q         <= '0;
      tobase_q       <= '0;
      conflict_q     <= 1'b0;
      conflict_idx_q <= '0;
      for (int k = 0; k < int'(N); k++) begin
        pos_q[k] <= '0;
        neg_q[k] <= '0;
        if (learnt_q[k]) begin
          valid_q[k] <= 1'b0;
          len_q[k]   <= '0;
        end
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          for (int k = 0; k < int'(N); k++) begin
            if (wr_i[k]) begin
              lit_q[k]    <= lit_i;
              len_q[k]    <= clause_len_i;
              learnt_q[k] <= learnt_i;
              valid_q[k]  <= 1'b1;
            end
          end
          if (start_i) begin
            for (int i = 0; i < int'(V); i++) begin
              asg_q[i] <= var_value_frombase_i[3*i+2];
              val_q[i] <= var_value_frombase_i[3*i+1];
            end
          end
        end
        StS1: begin
          conf_q <= st_conf;
          for (int k = 0; k < int'(N); k++) begin
            pos_q[k] <= st_unit[k] ? (free_v[k] & pol_v[k])  : '0;
            neg_q[k] <= st_unit[k] ? (free_v[k] & ~pol_v[k]) : '0;
          end
        end
        StS2: begin
          tobase_q       <= tobase_d;
          conflict_q     <= conflict_d;
          conflict_idx_q <= conflict_idx_d;
        end
        default: ;
      endcase
    end
  end

  // Free-slot search and status outputs
  always_comb begin
    free_idx_o   = '0;
    clause_len_o = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (!valid_q[k]) free_idx_o = WIDTH_C_IDX'(k);
    end
    for (int k = 0; k < int'(N); k++) begin
      clause_len_o[(int'(N) - 1 - k)*int'(WIDTH_C_LEN) +: WIDTH_C_LEN] = len_q[k];
    end
  end

  assign full_o             = &valid_q;
  assign busy_o             = (state_q != StIdle);
  assign done_o             = (state_q == StS3);
  assign var_value_tobase_o = tobase_q;
  assign conflict_o         = conflict_q;
  assign conflict_idx_o     = conflict_idx_q;

endmodule

// File: doc/clause_array_bcp.md
Name: clause_array_bcp

Overview:
- Parametrised successor of the two-clause bin: holds NUM_CLAUSES_A_BIN clauses of one bin in a single block.
- Adds literal storage, per-clause valid/learnt flags, and a 3-stage pipelined unit-propagation evaluation with conflict detection.
- Adds free-slot search so the learnt-clause index finder no longer scans clause_len externally.
- Sits between the bin base (variable states) and the learnt-clause manager.

Parameters:
- NUM_CLAUSES_A_BIN, 2, clauses per bin (>=1).
- NUM_VARS_A_BIN, 8, variables per bin (>=1).
- WIDTH_C_LEN, 5, clause length field width.
- WIDTH_C_IDX, 1, clause index width; must be >= clog2(NUM_CLAUSES_A_BIN), minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_i  in  NUM_CLAUSES_A_BIN  one-hot clause write strobe
- lit_i  in  2*NUM_VARS_A_BIN  per var {in_clause, polarity}; polarity 1 = positive literal
- learnt_i  in  1  written clause is learnt
- clause_len_i  in  WIDTH_C_LEN  length of the written clause
- start_i  in  1  evaluation request pulse
- var_value_frombase_i  in  3*NUM_VARS_A_BIN  per var {assigned, value, unused}
- var_value_tobase_o  out  3*NUM_VARS_A_BIN  per var {implied, value, imply_conflict}
- clause_len_o  out  WIDTH_C_LEN*NUM_CLAUSES_A_BIN  stored lengths; clause 0 in the MSB slice
- apply_backtrack_i  in  1  invalidate all learnt clauses; abort evaluation
- busy_o  out  1  evaluation in flight
- done_o  out  1  one-cycle pulse, results valid
- conflict_o  out  1  conflict found
- conflict_idx_o  out  WIDTH_C_IDX  lowest-index falsified clause
- free_idx_o  out  WIDTH_C_IDX  lowest invalid clause slot
- full_o  out  1  no invalid slot

Behaviour:
- Reset: all clauses invalid, literals, lengths and learnt flags 0; FSM in IDLE.
- Output values at reset: busy_o=0, done_o=0, conflict_o=0, conflict_idx_o=0, tobase all 0, free_idx_o=0, full_o=0.
- Write:
  - In IDLE, wr_i[k] loads lit_i, clause_len_i and learnt_i into clause k and sets valid[k]=1.
  - Non-one-hot wr_i writes every selected clause.
  - wr_i while busy_o=1 is ignored.
- Literal semantics, for a valid clause and a present literal:
  - TRUE when assigned=1 and value==polarity.
  - FALSE when assigned=1 and value!=polarity.
  - FREE when assigned=0.
- Clause status:
  - SAT if any literal is TRUE.
  - Otherwise CONFLICT if all literals are FALSE; a clause with zero literals is CONFLICT.
  - Otherwise UNIT if exactly one literal is FREE.
  - Otherwise OPEN.
  - Invalid clauses are OPEN.
- FSM IDLE -> S1 -> S2 -> S3 -> IDLE:
  - IDLE: start_i=1 registers var_value_frombase_i, busy_o=1, go to S1.
  - S1: per-clause status registered.
  - S2: implication OR-reduction and lowest-index conflict priority encode registered.
  - S3: outputs updated; done_o=1 for this cycle; busy_o=0 from the next cycle.
  - Latency: start_i accepted at cycle T gives done_o at T+3. The next start is accepted at T+4.
- start_i while busy_o=1 is ignored (no queueing).
- Implication output:
  - For each UNIT clause, its FREE var gets implied=1 and value=polarity.
  - Multiple units on the same var with the same polarity are OR-merged.
  - Opposite polarities set imply_conflict=1 and value=1 on that var.
- conflict_o = any CONFLICT clause OR any imply_conflict. conflict_idx_o = lowest CONFLICT index, else 0.
- All evaluation outputs hold until the next done_o, backtrack or reset.
- apply_backtrack_i (any state):
  - Next cycle: every clause with learnt=1 gets valid=0 and len=0.
  - FSM returns to IDLE with no done_o; evaluation outputs cleared to 0.
  - Original clauses are untouched.
- Backtrack has priority over start_i and wr_i in the same cycle.
- free_idx_o / full_o:
  - Combinational from registered valid flags; lowest index with valid=0.
  - full_o=1 and free_idx_o=0 when all slots are valid.
- rst mid-evaluation: back to IDLE next cycle, all state cleared, no done_o.

Test Plan:
- N=2,V=8. Write c0 = (x0 + ~x1) as lit bits 0/1, len 2; write c1 = (x2) learnt, len 1. Result: clause_len_o={5'd2,5'd1}, full_o=1.
- x0 unassigned, x1 assigned=1 value=1, x2 unassigned; start at T -> done_o at T+3 only. tobase var0={1,1,0}, var2={1,1,0}, conflict_o=0.
- x2 assigned value 0 -> c1 CONFLICT: conflict_o=1, conflict_idx_o=1. Then apply_backtrack_i -> c1 invalid, len 0, free_idx_o=1, full_o=0.
- Two units imply var3 with opposite polarity -> var3={1,1,1}, conflict_o=1.
- start_i at T, apply_backtrack_i at T+1 -> no done_o, busy_o=0 at T+2, outputs 0. Repeat with rst at T+1: same result, all clauses invalid.
- start_i and wr_i pulsed while busy -> ignored: single done_o, stored contents unchanged.
